// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and BCD decode function (active-high, bit order gfedcba).
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

  // Codes 10..15 are not valid BCD and render as a dash.
  function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
    seg_t pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational 4-bit BCD to 7-segment decoder (active-high gfedcba).
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = bcd_to_seg(i_bcd);
  end

endmodule

// File: rtl/bcd_seg7_scan_driver.sv
// Multiplexed 7-segment display driver: shadows BCD digits on load and scans them one per slot.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned PRESCALE       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [2:0]              digit_idx,
  output logic                    frame_tick
);

  localparam int unsigned     CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [2:0]      IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [2:0]              r_idx;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [NUM_DIGITS-1:0]   r_dp;

  logic [6:0]              r_seg;
  logic                    r_dp_out;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [2:0]              r_digit_idx;
  logic                    r_frame_tick;

  logic                    w_tick;
  logic                    w_wrap;
  logic [3:0]              w_digit;
  logic                    w_digit_dp;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_an_onehot;
  logic [NUM_DIGITS-1:0]   w_blank_vec;
  logic [6:0]              w_seg_raw;
  logic [6:0]              w_seg_lit;
`ifdef LEADING_ZERO_BLANK_EN
  logic                    w_run;
`endif

  assign w_tick = (r_cnt == CNT_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_tick) begin
      r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd <= '0;
      r_dp  <= '0;
    end else if (load) begin
      r_bcd <= bcd_in;
      r_dp  <= dp_in;
    end
  end

  // A digit is blanked while it and every digit above it are zero with no dp; digit 0 always shows.
  always_comb begin
    w_blank_vec = '0;
`ifdef LEADING_ZERO_BLANK_EN
    w_run = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_run          = w_run && (r_bcd[4*i +: 4] == 4'd0) && !r_dp[i];
      w_blank_vec[i] = w_run;
    end
`endif
  end

  always_comb begin
    w_digit     = '0;
    w_digit_dp  = 1'b0;
    w_blank     = 1'b0;
    w_an_onehot = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == 3'(i)) begin
        w_digit        = r_bcd[4*i +: 4];
        w_digit_dp     = r_dp[i];
        w_blank        = w_blank_vec[i];
        w_an_onehot[i] = 1'b1;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg_raw)
  );

  assign w_seg_lit = w_blank ? SEG_BLANK : w_seg_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg        <= {7{SEG_ACTIVE_LOW}};
      r_dp_out     <= SEG_ACTIVE_LOW;
      r_an         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      r_digit_idx  <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= w_seg_lit ^ {7{SEG_ACTIVE_LOW}};
      r_dp_out     <= (w_digit_dp && !w_blank) ^ SEG_ACTIVE_LOW;
      r_an         <= w_an_onehot ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
      r_digit_idx  <= r_idx;
      r_frame_tick <= w_wrap;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp_out;
  assign an         = r_an;
  assign digit_idx  = r_digit_idx;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_bcd_seg7_scan_driver.sv
// Self-checking bench for bcd_seg7_scan_driver (NUM_DIGITS=4, PRESCALE=4, active-low seg and an).
module tb_bcd_seg7_scan_driver;

  localparam int unsigned N = 4;
  localparam int unsigned P = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [2:0]  digit_idx;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;

  // Reference model: edges since reset and the shadowed display contents.
  int unsigned m_k;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic [2:0]  e_idx;
  logic        e_ft;

  logic [6:0] ref_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  bcd_seg7_scan_driver #(
    .NUM_DIGITS     (4),
    .PRESCALE       (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  // Predict the outputs produced by the coming edge, then advance one clock.
  task automatic step();
    int unsigned d;
    logic [3:0]  v;
    logic [6:0]  pat;
    logic        bl;
    if (rst) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_idx = 3'd0; e_ft = 1'b0;
      m_k = 0; m_sh = '0; m_dp = '0;
    end else begin
      d   = (m_k / P) % N;
      v   = 4'((m_sh >> (4*d)) & 16'h000F);
      pat = (v < 4'd10) ? ref_tbl[int'(v)] : 7'h40;
      bl  = LZB && (d > 0) && ((m_sh >> (4*d)) == 16'd0) && ((m_dp >> d) == 4'd0);
      if (bl) pat = 7'h00;
      e_seg = ~pat;
      e_dp  = ~(m_dp[d] & ~bl);
      e_an  = ~(4'b0001 << d);
      e_idx = 3'(d);
      if (load) begin
        m_sh = bcd_in;
        m_dp = dp_in;
      end
      m_k  = m_k + 1;
      e_ft = (m_k % (P*N)) == 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; bcd_in = 16'hFFFF; dp_in = 4'hF;
    repeat (3) step();
    checks++;
    if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    checks++;
    if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
    checks++;
    if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%h exp=f", an); end
    checks++;
    if (digit_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", digit_idx); end
    checks++;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft got=%b exp=0", frame_tick); end
    load = 1'b0;
    rst  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({seg, dp, an, digit_idx, frame_tick} !== {e_seg, e_dp, e_an, e_idx, e_ft}) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got seg=%h dp=%b an=%h idx=%0d ft=%b exp seg=%h dp=%b an=%h idx=%0d ft=%b",
                 i, seg, dp, an, digit_idx, frame_tick, e_seg, e_dp, e_an, e_idx, e_ft);
      end
    end
  endtask

  task automatic test_scan_1234();
    logic [6:0] want;
    int         nft;
    nft = 0;
    load = 1'b1; bcd_in = 16'h1234; dp_in = 4'h0;
    step();
    load = 1'b0;
    for (int i = 0; i < 48; i++) begin
      step();
      checks++;
      if ({seg, dp, an, digit_idx, frame_tick} !== {e_seg, e_dp, e_an, e_idx, e_ft}) begin
        errors++;
        $display("FAIL scan_1234 cyc=%0d got seg=%h dp=%b an=%h idx=%0d ft=%b exp seg=%h dp=%b an=%h idx=%0d ft=%b",
                 i, seg, dp, an, digit_idx, frame_tick, e_seg, e_dp, e_an, e_idx, e_ft);
      end
      case (an)
        4'hE:    want = 7'h19;
        4'hD:    want = 7'h30;
        4'hB:    want = 7'h24;
        4'h7:    want = 7'h79;
        default: want = 7'hXX;
      endcase
      checks++;
      if (seg !== want) begin
        errors++;
        $display("FAIL scan_1234_table an=%h got seg=%h exp seg=%h", an, seg, want);
      end
      if (frame_tick === 1'b1) nft++;
    end
    checks++;
    if (nft != 3) begin errors++; $display("FAIL frame_tick_count got=%0d exp=3", nft); end
  endtask

  task automatic test_dash_dp();
    load = 1'b1; bcd_in = 16'h00A5; dp_in = 4'b0100;
    step();
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({seg, dp, an, digit_idx, frame_tick} !== {e_seg, e_dp, e_an, e_idx, e_ft}) begin
        errors++;
        $display("FAIL dash_dp cyc=%0d got seg=%h dp=%b an=%h idx=%0d ft=%b exp seg=%h dp=%b an=%h idx=%0d ft=%b",
                 i, seg, dp, an, digit_idx, frame_tick, e_seg, e_dp, e_an, e_idx, e_ft);
      end
      if (i > 0 && an == 4'hD) begin
        checks++;
        if (seg !== 7'h3F) begin errors++; $display("FAIL dash_digit1 got seg=%h exp seg=3f", seg); end
      end
      if (i > 0 && an == 4'hB) begin
        checks++;
        if ({seg, dp} !== {7'h40, 1'b0}) begin
          errors++;
          $display("FAIL zero_dp_digit2 got seg=%h dp=%b exp seg=40 dp=0", seg, dp);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] pats [2] = '{16'h0007, 16'h0000};
    logic [6:0]  want;
    for (int p = 0; p < 2; p++) begin
      load = 1'b1; bcd_in = pats[p]; dp_in = 4'h0;
      step();
      load = 1'b0;
      for (int i = 0; i < 18; i++) begin
        step();
        checks++;
        if ({seg, dp, an, digit_idx, frame_tick} !== {e_seg, e_dp, e_an, e_idx, e_ft}) begin
          errors++;
          $display("FAIL leading_zero pat=%h cyc=%0d got seg=%h dp=%b an=%h idx=%0d ft=%b exp seg=%h dp=%b an=%h idx=%0d ft=%b",
                   pats[p], i, seg, dp, an, digit_idx, frame_tick, e_seg, e_dp, e_an, e_idx, e_ft);
        end
        if (i > 0) begin
          if (an == 4'hE) want = (p == 0) ? 7'h78 : 7'h40;
          else            want = LZB ? 7'h7F : 7'h40;
          checks++;
          if (seg !== want) begin
            errors++;
            $display("FAIL leading_zero_table pat=%h an=%h got seg=%h exp seg=%h", pats[p], an, seg, want);
          end
        end
      end
    end
  endtask

  task automatic test_load_on_tick();
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < 8 && (m_k % P) != P - 1; w++) step();
      load = 1'b1; bcd_in = 16'($urandom); dp_in = 4'($urandom);
      step();
      load = 1'b0;
      step();
      checks++;
      if ({seg, dp, an, digit_idx, frame_tick} !== {e_seg, e_dp, e_an, e_idx, e_ft}) begin
        errors++;
        $display("FAIL load_on_tick r=%0d got seg=%h dp=%b an=%h idx=%0d ft=%b exp seg=%h dp=%b an=%h idx=%0d ft=%b",
                 r, seg, dp, an, digit_idx, frame_tick, e_seg, e_dp, e_an, e_idx, e_ft);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int w = 0; w < 64 && !(((m_k / P) % N) == 2 && (m_k % P) == 1); w++) step();
    rst = 1'b1; load = 1'b1; bcd_in = 16'h9999; dp_in = 4'hF;
    step();
    rst = 1'b0; load = 1'b0;
    checks++;
    if ({seg, dp, an, digit_idx, frame_tick} !== {7'h7F, 1'b1, 4'hF, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got seg=%h dp=%b an=%h idx=%0d ft=%b exp seg=7f dp=1 an=f idx=0 ft=0",
               seg, dp, an, digit_idx, frame_tick);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++;
      if ({seg, dp, an, digit_idx, frame_tick} !== {e_seg, e_dp, e_an, e_idx, e_ft}) begin
        errors++;
        $display("FAIL reset_mid_run cyc=%0d got seg=%h dp=%b an=%h idx=%0d ft=%b exp seg=%h dp=%b an=%h idx=%0d ft=%b",
                 i, seg, dp, an, digit_idx, frame_tick, e_seg, e_dp, e_an, e_idx, e_ft);
      end
      if (i == 4 || i == 5) begin
        checks++;
        if (digit_idx !== ((i == 4) ? 3'd0 : 3'd1)) begin
          errors++;
          $display("FAIL prescale_restart cyc=%0d got idx=%0d exp idx=%0d", i, digit_idx, (i == 4) ? 0 : 1);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 5) == 0);
      v = '0;
      for (int n = 0; n < 4; n++)
        if ($urandom_range(0, 9) >= 3) v = v | (16'($urandom_range(0, 15)) << (4*n));
      bcd_in = v;
      dp_in  = 4'(($urandom_range(0, 4) == 0) ? $urandom : 0);
      step();
      checks++;
      if ({seg, dp, an, digit_idx, frame_tick} !== {e_seg, e_dp, e_an, e_idx, e_ft}) begin
        errors++;
        $display("FAIL random cyc=%0d got seg=%h dp=%b an=%h idx=%0d ft=%b exp seg=%h dp=%b an=%h idx=%0d ft=%b",
                 i, seg, dp, an, digit_idx, frame_tick, e_seg, e_dp, e_an, e_idx, e_ft);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0;
    m_k = 0; m_sh = '0; m_dp = '0;
    #2;
    test_reset();
    test_scan_1234();
    test_dash_dp();
    test_leading_zero();
    test_load_on_tick();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
